// File: rtl/mem_interface.sv
// rtl/mem_interface.sv - MAR/MDR holding registers, 512x32 main RAM and wait-state access sequencer
module mem_interface #(
    parameter int          ADDR_W      = 9,
    parameter int          DATA_W      = 32,
    parameter int          DEPTH       = 2 ** ADDR_W,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              MARin,
    input  logic              mdr_in,
    input  logic              read,
    input  logic              memRead,
    input  logic              memWrite,
    output logic [ADDR_W-1:0] mar_q,
    output logic [DATA_W-1:0] mdr_q,
    output logic              busy,
    output logic              mem_done,
    output logic              mem_err
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_WAIT = 3'd1;
    localparam logic [2:0] RD_DO   = 3'd2;
    localparam logic [2:0] WR_WAIT = 3'd3;
    localparam logic [2:0] WR_DO   = 3'd4;

    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

    logic [DATA_W-1:0] ram [DEPTH];

    logic [2:0]        state;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              memRead_d;
    logic              memWrite_d;
    logic              rd_req;
    logic              wr_req;

    // Requests are rising edges of the level strobes, so a held request fires only once
    always_comb begin
        rd_req = memRead & ~memRead_d;
        wr_req = memWrite & ~memWrite_d;
        busy   = (state != IDLE);
    end

    // Request edge detectors
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            memRead_d  <= 1'b0;
            memWrite_d <= 1'b0;
        end else begin
            memRead_d  <= memRead;
            memWrite_d <= memWrite;
        end
    end

    // MAR load; the access uses addr_q, so MAR may change while an access is in flight
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            mar_q <= '0;
        end else if (MARin) begin
            mar_q <= bus_in[ADDR_W-1:0];
        end
    end

    // Access sequencer: wait-state countdown, MDR fill/load, completion and drop pulses
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            mdr_q    <= '0;
            mem_done <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            mem_done <= 1'b0;
            mem_err  <= 1'b0;

            // Bus load first so a read completion on the same edge takes priority
            if (mdr_in && !read) begin
                mdr_q <= bus_in;
            end

            case (state)
                IDLE: begin
                    if (rd_req) begin
                        state   <= RD_WAIT;
                        cnt     <= WS_INIT;
                        addr_q  <= mar_q;
                        mem_err <= wr_req;
                    end else if (wr_req) begin
                        state  <= WR_WAIT;
                        cnt    <= WS_INIT;
                        addr_q <= mar_q;
                    end
                end
                RD_WAIT: begin
                    if (cnt != '0) cnt <= cnt - 4'd1;
                    else           state <= RD_DO;
                end
                WR_WAIT: begin
                    if (cnt != '0) cnt <= cnt - 4'd1;
                    else           state <= WR_DO;
                end
                RD_DO: begin
                    mdr_q    <= ram[addr_q];
                    mem_done <= 1'b1;
                    state    <= IDLE;
                end
                WR_DO: begin
                    mem_done <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // A new request edge while an access is running is dropped
            if (state != IDLE && (rd_req || wr_req)) begin
                mem_err <= 1'b1;
            end
        end
    end

    // RAM write port; contents are deliberately not reset, and reset forces IDLE so no write commits
    always_ff @(posedge clk) begin
        if (state == WR_DO) begin
            ram[addr_q] <= mdr_q;
        end
    end

endmodule
